amstrad_mmu_replay: RTL and testbench

Bus-master sequencer that restores gate-array and PAL memory-mapping state from snapshot register values. It replays the values as a series of CPU-style I/O write cycles on the same `A`/`D`/`io_WR` bus the MMU decodes. It sits beside the Z80 in the motherboard and is driven by the snapshot loader. While the CPU is held off via a request/acknowledge handshake, it acts as the initiator end of the gate-array/MMU register protocol.

---
 rtl/amstrad_mmu_replay.sv | 205 ++++++++++++++++++++
 tb/tb_amstrad_mmu_replay.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amstrad_mmu_replay.sv
// amstrad_mmu_replay: replays snapshot gate-array / PAL mapping state as a
// sequence of CPU-style I/O writes (RMR, MMR, upper ROM select, and optionally
// the full palette) while the Z80 is held off the bus via bus_req/bus_ack.
// Optional feature macro: MMU_REPLAY_PALETTE_EN appends 35 palette writes.
module amstrad_mmu_replay #(
  parameter int STROBE_CYCLES = 4,
  parameter int GAP_CYCLES    = 4
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  rmr,
  input  logic [6:0]  ram_cfg,
  input  logic [7:0]  rom_sel,
  input  logic [4:0]  pen_sel,
  input  logic [84:0] inks,
  output logic        bus_req,
  input  logic        bus_ack,
  output logic        busy,
  output logic        done,
  output logic        io_WR,
  output logic [15:0] A,
  output logic [7:0]  D
);

`ifdef MMU_REPLAY_PALETTE_EN
  localparam int NUM_WRITES = 38;
`else
  localparam int NUM_WRITES = 3;
`endif
  localparam logic [5:0] LAST_IDX    = 6'(NUM_WRITES - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] GAP_LAST    = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_STROBE,
    S_GAP,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  idx_q, idx_d;

  // Payload captured when a replay is accepted; data only, so no reset.
  logic [5:0]  rmr_q, rmr_d;
  logic [6:0]  ram_cfg_q, ram_cfg_d;
  logic [7:0]  rom_sel_q, rom_sel_d;

  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

`ifdef MMU_REPLAY_PALETTE_EN
  logic [4:0]  pen_sel_q, pen_sel_d;
  logic [84:0] inks_q, inks_d;

  // Palette list starts at index 3: even offsets select pen i, odd offsets
  // write that pen's ink; index 37 restores the snapshot's pen selection.
  function automatic logic [7:0] pal_data(input logic [5:0] idx,
                                          input logic [4:0] pen,
                                          input logic [84:0] ink);
    logic [5:0] ofs;
    logic [4:0] pen_i;
    ofs   = idx - 6'd3;
    pen_i = ofs[5:1];
    if (idx == 6'd37) return {3'b000, pen};
    if (!ofs[0])      return {3'b000, pen_i};
    return {3'b010, ink[int'(pen_i) * 5 +: 5]};
  endfunction
`else
  logic unused_palette;
  assign unused_palette = ^{pen_sel, inks};
`endif

  // Address/data for the write selected by the current list index.
  always_comb begin
    wr_addr = 16'h7F00;
    wr_data = 8'h00;
    case (idx_q)
      6'd0: wr_data = {2'b10, rmr_q};
      6'd1: begin
        wr_addr = ram_cfg_q[6] ? 16'h7E00 : 16'h7F00;
        wr_data = {2'b11, ram_cfg_q[5:0]};
      end
      6'd2: begin
        wr_addr = 16'hDF00;
        wr_data = rom_sel_q;
      end
      default: begin
`ifdef MMU_REPLAY_PALETTE_EN
        wr_data = pal_data(idx_q, pen_sel_q, inks_q);
`else
        wr_data = 8'h00;
`endif
      end
    endcase
  end

  // Sequencer next-state, counters, payload capture and bus outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rmr_d     = rmr_q;
    ram_cfg_d = ram_cfg_q;
    rom_sel_d = rom_sel_q;
`ifdef MMU_REPLAY_PALETTE_EN
    pen_sel_d = pen_sel_q;
    inks_d    = inks_q;
`endif
    bus_req   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    io_WR     = 1'b0;
    A         = 16'h0000;
    D         = 8'h00;
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        idx_d = 6'd0;
        if (start) begin
          rmr_d     = rmr;
          ram_cfg_d = ram_cfg;
          rom_sel_d = rom_sel;
`ifdef MMU_REPLAY_PALETTE_EN
          pen_sel_d = pen_sel;
          inks_d    = inks;
`endif
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        if (bus_ack) begin
          cnt_d   = 8'd0;
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        io_WR   = 1'b1;
        A       = wr_addr;
        D       = wr_data;
        if (cnt_q == STROBE_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        A       = wr_addr;
        D       = wr_data;
        if (cnt_q == GAP_LAST) begin
          cnt_d = 8'd0;
          if (idx_q == LAST_IDX) begin
            idx_d   = 6'd0;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = S_STROBE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Latched payload registers.
  always_ff @(posedge CLK) begin
    rmr_q     <= rmr_d;
    ram_cfg_q <= ram_cfg_d;
    rom_sel_q <= rom_sel_d;
`ifdef MMU_REPLAY_PALETTE_EN
    pen_sel_q <= pen_sel_d;
    inks_q    <= inks_d;
`endif
  end

endmodule

// File: tb/tb_amstrad_mmu_replay.sv
// Bench for amstrad_mmu_replay: random and directed replays compared against
// a write-list model built directly from the payload values.
module tb_amstrad_mmu_replay;
  localparam int S = 4;
  localparam int G = 4;
`ifdef MMU_REPLAY_PALETTE_EN
  localparam int N = 38;
`else
  localparam int N = 3;
`endif
  localparam int BUDGET = 800;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        bus_ack = 1'b0;
  logic [5:0]  rmr = '0;
  logic [6:0]  ram_cfg = '0;
  logic [7:0]  rom_sel = '0;
  logic [4:0]  pen_sel = '0;
  logic [84:0] inks = '0;
  logic        bus_req, busy, done, io_WR;
  logic [15:0] A;
  logic [7:0]  D;

  amstrad_mmu_replay #(.STROBE_CYCLES(S), .GAP_CYCLES(G)) dut (
    .CLK(CLK), .reset_n(reset_n), .start(start), .rmr(rmr), .ram_cfg(ram_cfg),
    .rom_sel(rom_sel), .pen_sel(pen_sel), .inks(inks), .bus_req(bus_req),
    .bus_ack(bus_ack), .busy(busy), .done(done), .io_WR(io_WR), .A(A), .D(D)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] exp_a[$];
  logic [7:0]  exp_d[$];
  logic [15:0] got_a[$];
  logic [7:0]  got_d[$];
  int          hi_len[$];
  int          lo_len[$];
  int first_rise, done_cyc, done_cnt, unstable, bad_ctrl, wait_bad, dirty_done, post_busy;
  bit timed_out;

  // Reference write list derived from the current payload inputs.
  task automatic build_expected();
    exp_a.delete();
    exp_d.delete();
    exp_a.push_back(16'h7F00); exp_d.push_back({2'b10, rmr});
    exp_a.push_back(ram_cfg[6] ? 16'h7E00 : 16'h7F00); exp_d.push_back({2'b11, ram_cfg[5:0]});
    exp_a.push_back(16'hDF00); exp_d.push_back(rom_sel);
`ifdef MMU_REPLAY_PALETTE_EN
    for (int i = 0; i < 17; i++) begin
      exp_a.push_back(16'h7F00); exp_d.push_back(8'(i));
      exp_a.push_back(16'h7F00); exp_d.push_back(8'h40 + 8'((inks >> (5 * i)) & 85'h1F));
    end
    exp_a.push_back(16'h7F00); exp_d.push_back({3'b000, pen_sel});
`endif
  endtask

  task automatic randomize_payload();
    rmr     = 6'($urandom);
    ram_cfg = 7'($urandom);
    rom_sel = 8'($urandom);
    pen_sel = 5'($urandom);
    inks    = {21'($urandom), 32'($urandom), 32'($urandom)};
  endtask

  task automatic set_basic_payload();
    rmr = 6'h0C; ram_cfg = 7'h41; rom_sel = 8'h07;
  endtask

  // Pulses start, grants after ack_delay cycles, records every write seen on
  // the bus; optionally pokes rom_sel/start at cycle poke_cyc.
  task automatic capture(input int ack_delay, input int poke_cyc);
    int cyc, hi, lo;
    bit prev_wr;
    logic [15:0] cur_a;
    logic [7:0]  cur_d;
    got_a.delete(); got_d.delete(); hi_len.delete(); lo_len.delete();
    first_rise = -1; done_cyc = -1; done_cnt = 0; unstable = 0; bad_ctrl = 0;
    wait_bad = 0; dirty_done = 0; post_busy = 0; timed_out = 0;
    prev_wr = 0; hi = 0; lo = 0; cyc = 0; cur_a = '0; cur_d = '0;
    bus_ack = (ack_delay == 0);
    start = 1'b1;
    forever begin
      @(negedge CLK);
      cyc++;
      start = 1'b0;
      if (io_WR && !prev_wr && done_cyc < 0) begin
        if (first_rise >= 0) begin hi_len.push_back(hi); lo_len.push_back(lo); end
        else first_rise = cyc;
        cur_a = A; cur_d = D;
        got_a.push_back(A); got_d.push_back(D);
        hi = 0; lo = 0;
      end
      if (first_rise >= 0 && done_cyc < 0 && !done) begin
        if (io_WR) hi++; else lo++;
        if (A !== cur_a || D !== cur_d) unstable++;
        if (bus_req !== 1'b1 || busy !== 1'b1) bad_ctrl++;
      end
      if (!bus_ack && (bus_req !== 1'b1 || busy !== 1'b1 || io_WR !== 1'b0)) wait_bad++;
      if (done_cyc >= 0 && cyc > done_cyc && (busy || bus_req || io_WR)) post_busy++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          if (first_rise >= 0) begin hi_len.push_back(hi); lo_len.push_back(lo); end
        end
        if (bus_req !== 1'b0 || busy !== 1'b0 || io_WR !== 1'b0 || A !== 16'h0 || D !== 8'h0)
          dirty_done++;
      end
      prev_wr = io_WR;
      if (cyc == ack_delay) bus_ack = 1'b1;
      if (cyc == poke_cyc) begin rom_sel = 8'hFF; start = 1'b1; end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
      if (cyc >= BUDGET) begin timed_out = 1; break; end
    end
    start = 1'b0;
    bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    randomize_payload();
    start = 1'b1; bus_ack = 1'b1;
    repeat (3) @(negedge CLK);
    vectors++;
    if ({bus_req, busy, done, io_WR, A, D} !== 28'h0)
      begin miscompares++; $display("FAIL reset_outputs got=%h want=0", {bus_req, busy, done, io_WR, A, D}); end
    start = 1'b0; bus_ack = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      vectors++;
      if ({bus_req, busy, done, io_WR, A, D} !== 28'h0)
        begin miscompares++; $display("FAIL post_reset_idle cyc=%0d got=%h want=0", i, {bus_req, busy, done, io_WR, A, D}); end
    end
  endtask

  task automatic test_basic();
    set_basic_payload();
    build_expected();
    capture(0, -1);
    vectors++;
    if (timed_out || got_a.size() != N)
      begin miscompares++; $display("FAIL basic_count got=%0d want=%0d timeout=%0d", got_a.size(), N, timed_out); end
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (i >= got_a.size() || got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i])
        begin miscompares++; $display("FAIL basic_write%0d got=%h/%h want=%h/%h", i,
          (i < got_a.size()) ? got_a[i] : 16'hxxxx, (i < got_d.size()) ? got_d[i] : 8'hxx, exp_a[i], exp_d[i]); end
    end
    for (int i = 0; i < hi_len.size(); i++) begin
      vectors++;
      if (hi_len[i] != S || lo_len[i] != G)
        begin miscompares++; $display("FAIL basic_widths write%0d got=%0d/%0d want=%0d/%0d", i, hi_len[i], lo_len[i], S, G); end
    end
    vectors++;
    if (first_rise != 2)
      begin miscompares++; $display("FAIL basic_first_rise got=%0d want=2", first_rise); end
    vectors++;
    if (done_cyc - first_rise != N * (S + G))
      begin miscompares++; $display("FAIL basic_done_latency got=%0d want=%0d", done_cyc - first_rise, N * (S + G)); end
    vectors++;
    if (done_cnt != 1 || dirty_done != 0)
      begin miscompares++; $display("FAIL basic_done got=%0d/%0d want=1/0", done_cnt, dirty_done); end
    vectors++;
    if (unstable != 0 || bad_ctrl != 0)
      begin miscompares++; $display("FAIL basic_stable got=%0d/%0d want=0/0", unstable, bad_ctrl); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int d, want_rise;
      d = int'($urandom_range(0, 5));
      want_rise = (d == 0) ? 2 : d + 1;
      randomize_payload();
      build_expected();
      capture(d, -1);
      vectors++;
      if (timed_out || got_a.size() != N)
        begin miscompares++; $display("FAIL random%0d_count got=%0d want=%0d", t, got_a.size(), N); end
      for (int i = 0; i < N && i < got_a.size(); i++) begin
        vectors++;
        if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i])
          begin miscompares++; $display("FAIL random%0d_write%0d got=%h/%h want=%h/%h", t, i, got_a[i], got_d[i], exp_a[i], exp_d[i]); end
      end
      vectors++;
      if (first_rise != want_rise || done_cyc - first_rise != N * (S + G))
        begin miscompares++; $display("FAIL random%0d_timing got=%0d/%0d want=%0d/%0d", t, first_rise, done_cyc - first_rise, want_rise, N * (S + G)); end
      vectors++;
      if (unstable != 0 || bad_ctrl != 0 || dirty_done != 0 || done_cnt != 1)
        begin miscompares++; $display("FAIL random%0d_ctrl got=%0d/%0d/%0d/%0d want=0/0/0/1", t, unstable, bad_ctrl, dirty_done, done_cnt); end
    end
  endtask

  task automatic test_delayed_grant();
    set_basic_payload();
    build_expected();
    capture(10, -1);
    vectors++;
    if (wait_bad != 0)
      begin miscompares++; $display("FAIL grant_wait got=%0d bad cycles want=0", wait_bad); end
    vectors++;
    if (first_rise != 11)
      begin miscompares++; $display("FAIL grant_first_rise got=%0d want=11", first_rise); end
    vectors++;
    if (got_a.size() != N || got_a[0] !== 16'h7F00 || got_d[0] !== 8'h8C)
      begin miscompares++; $display("FAIL grant_first_write count=%0d want=%0d", got_a.size(), N); end
  endtask

  task automatic test_latching();
    set_basic_payload();
    build_expected();
    capture(0, 10);
    vectors++;
    if (got_a.size() < 3 || got_d[2] !== 8'h07)
      begin miscompares++; $display("FAIL latch_rom_sel got=%h want=07", (got_d.size() > 2) ? got_d[2] : 8'hxx); end
    vectors++;
    if (done_cnt != 1 || post_busy != 0)
      begin miscompares++; $display("FAIL latch_single_done got=%0d/%0d want=1/0", done_cnt, post_busy); end
    // start pulsed exactly in the done cycle must not begin a new replay
    set_basic_payload();
    build_expected();
    capture(0, 2 + N * (S + G));
    vectors++;
    if (done_cyc != 2 + N * (S + G) || post_busy != 0 || done_cnt != 1)
      begin miscompares++; $display("FAIL done_cycle_start got=%0d/%0d/%0d want=%0d/0/1", done_cyc, post_busy, done_cnt, 2 + N * (S + G)); end
    repeat (2) @(negedge CLK);
    vectors++;
    if (busy !== 1'b0 || bus_req !== 1'b0)
      begin miscompares++; $display("FAIL done_cycle_idle got=%b%b want=00", busy, bus_req); end
  endtask

  task automatic test_async_reset();
    int rises, cyc;
    bit prev;
    set_basic_payload();
    build_expected();
    bus_ack = 1'b1; start = 1'b1;
    rises = 0; cyc = 0; prev = 0;
    while (rises < 2 && cyc < 100) begin
      @(negedge CLK);
      start = 1'b0;
      cyc++;
      if (io_WR && !prev) rises++;
      prev = io_WR;
    end
    vectors++;
    if (rises != 2)
      begin miscompares++; $display("FAIL areset_reach_second got=%0d rises want=2", rises); end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({io_WR, bus_req, busy, done} !== 4'b0000)
      begin miscompares++; $display("FAIL areset_drop got=%b want=0000", {io_WR, bus_req, busy, done}); end
    bus_ack = 1'b0;
    @(negedge CLK);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0)
        begin miscompares++; $display("FAIL areset_no_done cyc=%0d got=%b%b want=00", i, done, busy); end
    end
    capture(0, -1);
    vectors++;
    if (got_a.size() != N || got_a[0] !== 16'h7F00 || got_d[0] !== 8'h8C || done_cnt != 1)
      begin miscompares++; $display("FAIL areset_replay count=%0d first=%h/%h want=%0d 7f00/8c",
        got_a.size(), (got_a.size() > 0) ? got_a[0] : 16'hxxxx, (got_d.size() > 0) ? got_d[0] : 8'hxx, N); end
  endtask

`ifdef MMU_REPLAY_PALETTE_EN
  task automatic test_palette();
    set_basic_payload();
    for (int i = 0; i < 16; i++) inks[5 * i +: 5] = 5'(i);
    inks[80 +: 5] = 5'h14;
    pen_sel = 5'h03;
    build_expected();
    capture(0, -1);
    vectors++;
    if (got_a.size() != 38)
      begin miscompares++; $display("FAIL palette_count got=%0d want=38", got_a.size()); end
    else begin
      vectors++;
      if ({got_a[3], got_d[3], got_a[4], got_d[4]} !== {16'h7F00, 8'h00, 16'h7F00, 8'h40})
        begin miscompares++; $display("FAIL palette_pen0 got=%h/%h %h/%h want=7f00/00 7f00/40", got_a[3], got_d[3], got_a[4], got_d[4]); end
      vectors++;
      if ({got_a[35], got_d[35], got_a[36], got_d[36]} !== {16'h7F00, 8'h10, 16'h7F00, 8'h54})
        begin miscompares++; $display("FAIL palette_border got=%h/%h %h/%h want=7f00/10 7f00/54", got_a[35], got_d[35], got_a[36], got_d[36]); end
      vectors++;
      if (got_a[37] !== 16'h7F00 || got_d[37] !== 8'h03)
        begin miscompares++; $display("FAIL palette_last got=%h/%h want=7f00/03", got_a[37], got_d[37]); end
      for (int i = 0; i < 38; i++) begin
        vectors++;
        if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i])
          begin miscompares++; $display("FAIL palette_write%0d got=%h/%h want=%h/%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_delayed_grant();
    test_latching();
    test_async_reset();
`ifdef MMU_REPLAY_PALETTE_EN
    test_palette();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
